// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and receiver.
// Holds mode-byte bit positions, the bit-rate divisors, the divisor
// decode function and the frame state encoding.
package serial_pkg;

  localparam int unsigned MODE_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DIV_W     = 16;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned BIT_CNT_W = 3;

  // Operating-mode byte field positions; bits [4:2] are reserved.
  localparam int unsigned MODE_BAUD_HI = 7;
  localparam int unsigned MODE_BAUD_LO = 6;
  localparam int unsigned MODE_STOP    = 5;
  localparam int unsigned MODE_PAR_ODD = 1;
  localparam int unsigned MODE_PAR_EN  = 0;

  // Clocks per serial bit for each bit-rate select code.
  localparam logic [DIV_W-1:0] DIV_SEL0 = 16'd10416;
  localparam logic [DIV_W-1:0] DIV_SEL1 = 16'd5208;
  localparam logic [DIV_W-1:0] DIV_SEL2 = 16'd2604;
  localparam logic [DIV_W-1:0] DIV_SEL3 = 16'd868;

  // Frame state codes.
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP1  = 3'd4;
  localparam logic [STATE_W-1:0] ST_STOP2  = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP1  = ST_STOP1,
    S_STOP2  = ST_STOP2,
    S_DONE   = ST_DONE
  } frame_state_e;

  // Map the two bit-rate select bits to clocks per bit.
  function automatic logic [DIV_W-1:0] decode_divisor(input logic [1:0] sel);
    logic [DIV_W-1:0] div;
    case (sel)
      2'b00:   div = DIV_SEL0;
      2'b01:   div = DIV_SEL1;
      2'b10:   div = DIV_SEL2;
      default: div = DIV_SEL3;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period timer shared by transmitter and receiver.
// Ports: Clock, Reset_n (sync, active-low), enable, divisor (clocks per
// bit); tick_c is high during the last clock of each bit period.
// The counter is held at 0 while disabled, so it restarts from 0
// whenever enable rises.
module baud_tick_gen
  import serial_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_c = enable && (cnt_q == (divisor - DIV_W'(1)));

  // Count 0..divisor-1 while enabled.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (!enable || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx_frame.sv
// serial_tx_frame: UART-style transmitter. Sends start bit, D7..D0,
// optional parity, then one or two stop bits, all formatted by the
// operating-mode byte MODOS_DE_OPERACAO.
// Ports: Clock, Reset_n (sync, active-low), TX_DATA/TX_LOAD byte
// handshake, CTS gates frame start; TX_READY idle/accepting,
// DATA_OUT serial line (idles high), TX_DONE one-clock end pulse.
module serial_tx_frame
  import serial_pkg::*;
#(
  parameter logic [MODE_W-1:0] MODOS_DE_OPERACAO = 8'b10110101
)
(
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_LOAD,
  input  logic              CTS,
  output logic              TX_READY,
  output logic              DATA_OUT,
  output logic              TX_DONE
);

  localparam logic [DIV_W-1:0] DIV =
    decode_divisor(MODOS_DE_OPERACAO[MODE_BAUD_HI:MODE_BAUD_LO]);
  localparam logic PAR_EN   = MODOS_DE_OPERACAO[MODE_PAR_EN];
  localparam logic PAR_ODD  = MODOS_DE_OPERACAO[MODE_PAR_ODD];
  localparam logic ONE_STOP = MODOS_DE_OPERACAO[MODE_STOP];

  logic [STATE_W-1:0]   state_q,   state_d;
  logic [DATA_W-1:0]    shift_q,   shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 par_q,     par_d;
  logic                 data_out_d;
  logic                 ready_d;
  logic                 done_d;
  logic                 accept_c;
  logic                 baud_en_c;
  logic                 tick_c;

  assign accept_c  = TX_LOAD && TX_READY && CTS;
  assign baud_en_c = (state_q != ST_IDLE) && (state_q != ST_DONE);

  baud_tick_gen u_baud (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .enable  (baud_en_c),
    .divisor (DIV),
    .tick_c  (tick_c)
  );

  // State and output registers; DATA_OUT comes straight from a flop.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      DATA_OUT  <= 1'b1;
      TX_READY  <= 1'b1;
      TX_DONE   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      DATA_OUT  <= data_out_d;
      TX_READY  <= ready_d;
      TX_DONE   <= done_d;
    end
  end

  // Next-state and next-output logic; each value computed here is what
  // the line carries for the whole of the following bit period.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    data_out_d = DATA_OUT;
    ready_d    = TX_READY;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        data_out_d = 1'b1;
        ready_d    = 1'b1;
        if (accept_c) begin
          state_d    = ST_START;
          shift_d    = TX_DATA;
          par_d      = 1'b0;
          bit_cnt_d  = '0;
          data_out_d = 1'b0;
          ready_d    = 1'b0;
        end
      end

      ST_START: begin
        if (tick_c) begin
          state_d    = ST_DATA;
          data_out_d = shift_q[DATA_W-1];
          par_d      = par_q ^ shift_q[DATA_W-1];
          shift_d    = {shift_q[DATA_W-2:0], 1'b0};
          bit_cnt_d  = '0;
        end
      end

      ST_DATA: begin
        if (tick_c) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            // par_q now covers all eight data bits.
            if (PAR_EN) begin
              state_d    = ST_PARITY;
              data_out_d = par_q ^ PAR_ODD;
            end else begin
              state_d    = ST_STOP1;
              data_out_d = 1'b1;
            end
          end else begin
            data_out_d = shift_q[DATA_W-1];
            par_d      = par_q ^ shift_q[DATA_W-1];
            shift_d    = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (tick_c) begin
          state_d    = ST_STOP1;
          data_out_d = 1'b1;
        end
      end

      ST_STOP1: begin
        if (tick_c) begin
          data_out_d = 1'b1;
          if (ONE_STOP) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_STOP2;
          end
        end
      end

      ST_STOP2: begin
        if (tick_c) begin
          state_d    = ST_DONE;
          data_out_d = 1'b1;
          done_d     = 1'b1;
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        data_out_d = 1'b1;
        ready_d    = 1'b1;
      end

      default: begin
        state_d    = ST_IDLE;
        data_out_d = 1'b1;
        ready_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx_frame.sv
// tb_serial_tx_frame: three transmitter instances in different modes run
// side by side. Lane 0: default mode (2604, even parity, 1 stop).
// Lane 1: 868, odd parity, 2 stop. Lane 2: 5208, no parity, 1 stop.
module tb_serial_tx_frame;

  logic       clk;
  logic [2:0] rst_s;
  logic [2:0] load_s;
  logic [2:0] cts_s;
  logic [7:0] data_s [3];
  wire  [2:0] ready_s;
  wire  [2:0] dout_s;
  wire  [2:0] done_s;

  int checks_total  = 0;
  int checks_passed = 0;
  int done_cnt [3]  = '{0, 0, 0};
  int w0, w1, w2;

  serial_tx_frame #(.MODOS_DE_OPERACAO(8'b10110101)) u_dut_a (
    .Clock(clk), .Reset_n(rst_s[0]), .TX_DATA(data_s[0]), .TX_LOAD(load_s[0]),
    .CTS(cts_s[0]), .TX_READY(ready_s[0]), .DATA_OUT(dout_s[0]), .TX_DONE(done_s[0]));

  serial_tx_frame #(.MODOS_DE_OPERACAO(8'b11000011)) u_dut_b (
    .Clock(clk), .Reset_n(rst_s[1]), .TX_DATA(data_s[1]), .TX_LOAD(load_s[1]),
    .CTS(cts_s[1]), .TX_READY(ready_s[1]), .DATA_OUT(dout_s[1]), .TX_DONE(done_s[1]));

  serial_tx_frame #(.MODOS_DE_OPERACAO(8'b01100000)) u_dut_c (
    .Clock(clk), .Reset_n(rst_s[2]), .TX_DATA(data_s[2]), .TX_LOAD(load_s[2]),
    .CTS(cts_s[2]), .TX_READY(ready_s[2]), .DATA_OUT(dout_s[2]), .TX_DONE(done_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks during which TX_DONE is high, per lane.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_s[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one byte and check every bit of the resulting frame at the
  // first and last clock of its period, then the DONE pulse timing.
  task automatic send_frame(input int lane, input logic [7:0] b, input int div,
                            input bit par_en, input bit par_odd, input int stops,
                            input string tag, output int waited);
    logic exp_q[$];
    logic e;
    logic par;
    int   k;
    par = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(b[i]);
      par = par ^ b[i];
    end
    if (par_en) exp_q.push_back(par ^ par_odd);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);

    data_s[lane] = b;
    load_s[lane] = 1'b1;
    waited = 0;
    while (!(ready_s[lane] === 1'b1 && cts_s[lane] === 1'b1) && waited < 4 * div) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept_ready"}, 32'(ready_s[lane] & cts_s[lane]), 32'd1);
    if (ready_s[lane] !== 1'b1) begin
      load_s[lane] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    load_s[lane] = 1'b0;
    check({tag, "_busy"}, 32'(ready_s[lane]), 32'd0);

    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_b%0d_first", tag, k), 32'(dout_s[lane]), 32'(e));
      repeat (div - 1) @(negedge clk);
      check($sformatf("%s_b%0d_last", tag, k), 32'(dout_s[lane]), 32'(e));
      @(negedge clk);
      k++;
    end
    check({tag, "_done_pulse"}, {29'd0, done_s[lane], dout_s[lane], ready_s[lane]}, 32'b110);
    @(negedge clk);
    check({tag, "_idle_after"}, {29'd0, done_s[lane], dout_s[lane], ready_s[lane]}, 32'b011);
  endtask

  initial begin
    int bad;
    rst_s  = 3'b000;
    load_s = 3'b000;
    cts_s  = 3'b111;
    for (int i = 0; i < 3; i++) data_s[i] = 8'h00;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_l%0d", i), {29'd0, done_s[i], dout_s[i], ready_s[i]}, 32'b011);
    end
    rst_s = 3'b111;
    @(negedge clk);

    fork
      begin
        // Default mode frame, 11 bits of 2604 clocks.
        send_frame(0, 8'hA5, 2604, 1'b1, 1'b0, 1, "t1_a5", w0);

        // CTS low holds off the frame while TX_LOAD is asserted.
        cts_s[0]  = 1'b0;
        data_s[0] = 8'h69;
        load_s[0] = 1'b1;
        bad = 0;
        repeat (100) begin
          @(negedge clk);
          if (dout_s[0] !== 1'b1 || ready_s[0] !== 1'b1) bad++;
        end
        check("t4_cts_hold", 32'(bad), 32'd0);
        cts_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_s[0] = 1'b0;
        check("t4_start_bit", {30'd0, dout_s[0], ready_s[0]}, 32'b00);

        // Abort the frame in the middle of D3 (0x69 has D3=1).
        repeat (5 * 2604 + 1302) @(negedge clk);
        check("t5_in_d3", 32'(dout_s[0]), 32'd1);
        rst_s[0] = 1'b0;
        @(posedge clk);
        #1;
        check("t5_reset_edge", {29'd0, done_s[0], dout_s[0], ready_s[0]}, 32'b011);
        @(negedge clk);
        rst_s[0] = 1'b1;
        bad = 0;
        repeat (2 * 2604) begin
          @(negedge clk);
          if (done_s[0] !== 1'b0 || dout_s[0] !== 1'b1 || ready_s[0] !== 1'b1) bad++;
        end
        check("t5_quiet_after_abort", 32'(bad), 32'd0);
        send_frame(0, 8'h3C, 2604, 1'b1, 1'b0, 1, "t5_3c", w0);
      end
      begin
        // Fast odd-parity, two-stop frames sent back to back.
        send_frame(1, 8'h00, 868, 1'b1, 1'b1, 2, "t2_00", w1);
        send_frame(1, 8'h5A, 868, 1'b1, 1'b1, 2, "t6_b2b_5a", w1);
        check("t6_b2b_wait", 32'(w1), 32'd0);
      end
      begin
        // No-parity frame, 10 bits of 5208 clocks.
        send_frame(2, 8'hFF, 5208, 1'b0, 1'b0, 1, "t3_ff", w2);
      end
    join

    check("done_count_l0", 32'(done_cnt[0]), 32'd2);
    check("done_count_l1", 32'(done_cnt[1]), 32'd2);
    check("done_count_l2", 32'(done_cnt[2]), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/serial_tx_frame.md
Name: serial_tx_frame

Overview:
UART-style serial transmitter. It is the stage directly upstream of the serial receiver and drives that receiver's DATA_IN line. It accepts one byte per handshake and serialises it as: start bit, D7 first down to D0, optional parity bit, then one or two stop bits. Frame format and bit rate come from the same 8-bit operating-mode byte the receiver uses, so both ends agree by construction.

Parameters:
MODOS_DE_OPERACAO, 8'b10110101, operating-mode byte.
- [7:6] bit-rate select: 00→10416, 01→5208, 10→2604, 11→868 clocks per bit.
- [5] stop bits: 0 = two stop bits, 1 = one stop bit.
- [1] parity sense: 1 = odd, 0 = even.
- [0] parity enable.
- Bits [4:2] are reserved and ignored.

Ports:
Clock  input  1  system clock; the only clock.
Reset_n  input  1  synchronous, active-low reset.
TX_DATA  input  8  byte to send.
TX_LOAD  input  1  request to send TX_DATA.
CTS  input  1  clear-to-send from the far end; a frame may start only while CTS=1.
TX_READY  output  1  block is idle and will accept TX_LOAD this cycle.
DATA_OUT  output  1  serial line; idles high.
TX_DONE  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset: all state is synchronous to Clock and cleared when Reset_n=0 at a rising edge. Reset values: DATA_OUT=1, TX_READY=1, TX_DONE=0, state=IDLE, bit counter=0, shift register=0.
- Reset mid-frame: the frame is abandoned. DATA_OUT returns to 1 on that same edge and nothing is retransmitted.
- Divisor DIV: a constant decoded from bits [7:6]. The bit-period counter is 16 bits wide and counts 0..DIV-1. Every serial bit holds DATA_OUT for exactly DIV clocks.
- Accept condition: TX_LOAD=1 AND TX_READY=1 AND CTS=1 at a rising edge.
  - On accept: capture TX_DATA, clear the parity accumulator, and enter START.
  - DATA_OUT falls to 0 on that same edge, so latency from accept to the start bit is 1 clock.
- TX_LOAD while TX_READY=0 or CTS=0: ignored. Nothing is queued; the requester must hold TX_LOAD until the byte is accepted.
- CTS: sampled only in IDLE. Dropping CTS mid-frame does not stop the frame.
- States and transitions:
  - IDLE: DATA_OUT=1, TX_READY=1 → START on accept.
  - START: drive 0 for DIV clocks → DATA.
  - DATA: shift out MSB first, D7..D0, DIV clocks per bit. Accumulate the parity of ones. After D0 → PARITY if bit [0]=1, else STOP1.
  - PARITY: drive a bit that makes the total count of ones in data plus parity even (bit [1]=0) or odd (bit [1]=1) → STOP1.
  - STOP1: drive 1 → STOP2 if bit [5]=0, else DONE.
  - STOP2: drive 1 → DONE.
  - DONE: TX_DONE=1 for exactly one clock, DATA_OUT=1, TX_READY=0 → IDLE.
- Back-to-back frames: TX_READY returns to 1 on the cycle after DONE. Minimum line idle between frames is therefore 1 clock plus the back-to-back accept cycle.
- TX_READY=0 from the accept edge through DONE inclusive.
- Frame length in clocks = DIV × (1 + 8 + P + S), where P is 0 or 1 and S is 1 or 2.
- No glitches: DATA_OUT is driven straight from a flop.

Decomposition:
- Shared package serial_pkg, also used by the receiver:
  - mode-bit position constants: MODE_BAUD_HI=7, MODE_BAUD_LO=6, MODE_STOP=5, MODE_PAR_ODD=1, MODE_PAR_EN=0;
  - the four divisor constants 10416, 5208, 2604, 868;
  - a divisor-decode function;
  - the state enum for the frame states.
- Sub-module baud_tick_gen, reused by the receiver:
  - inputs: Clock, Reset_n, enable, divisor;
  - output: a 1-clock tick at the end of each bit period;
  - the counter restarts at 0 whenever enable rises.

Test Plan:
1. Default mode (DIV=2604, even parity, 1 stop), send 0xA5 with CTS=1 → line reads 0,1,0,1,0,0,1,0,1, parity 0, stop 1. Each bit lasts 2604 clocks and TX_DONE pulses 28644 clocks after accept.
2. MODOS=8'b11000011 (DIV=868, odd parity, 2 stop), send 0x00 → parity bit 1, two stop bits, 12×868 = 10416 clocks to TX_DONE.
3. MODOS=8'b01100000 (DIV=5208, no parity, 1 stop), send 0xFF → 10-bit frame, no parity slot, TX_DONE at 52080 clocks.
4. CTS=0 with TX_LOAD held for 100 clocks, then CTS=1 → DATA_OUT stays 1 and TX_READY stays 1 until CTS rises. The start bit begins 1 clock after the first cycle where CTS=1.
5. Reset_n=0 during D3 of a default-mode frame → next edge gives DATA_OUT=1, TX_READY=1, TX_DONE never pulses. A following 0x3C frame is transmitted correctly.
6. Loopback to the receiver block in default mode, bytes 0x00, 0x55, 0xA5, 0xFF sent back to back → the receiver reports each byte with no parity error, and TX_LOAD is accepted within 1 clock of TX_READY.
